uart_rx: RTL and testbench

//  Serial receiver, peer of the UART transmitter. Frame format: start(0), 8 data bits
//  MSB first, parity bit = (^data) ^ parity_type, stop(1). Each bit is CLKS_PER_BIT clocks.

---
 rtl/uart_rx.sv | 201 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver.
// Frame on the line: start(0), 8 data bits MSB first, one parity bit, stop(1).
// Each bit lasts CLKS_PER_BIT clocks. The parity bit equals (^data) ^ parity_type.
// Good frames are pushed to the receive FIFO with a one-cycle wr_en strobe.
// Bad frames (parity or stop-bit failure) still update rx_msg and are flagged.
// A good frame that arrives while the FIFO is full is dropped and flagged as an overrun.

module uart_rx #(
    parameter int CLKS_PER_BIT = 14,
    parameter int SAMPLE_POINT = 6
) (
    input  logic       clk_3125_rx,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       parity_type,
    input  logic       ft_full,
    output logic [7:0] rx_msg,
    output logic       wr_en,
    output logic       rx_complete,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun_err
);

    localparam int CNT_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int SYNC_STAGES = 2;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_POINT);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Synchroniser chain for the asynchronous serial line; flops idle high so
    // reset never looks like a start bit.
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rx_s;

    // Receiver state
    state_t           state_reg;
    logic [CNT_W-1:0] clk_cnt_reg;
    logic [2:0]       bit_cnt_reg;
    logic [7:0]       shift_reg;
    logic             par_bit_reg;

    // Registered outputs
    logic [7:0] rx_msg_reg;
    logic       wr_en_reg;
    logic       rx_complete_reg;
    logic       parity_err_reg;
    logic       frame_err_reg;
    logic       overrun_err_reg;

    // Frame checks evaluated at the stop-bit sample
    logic p_ok;
    logic s_ok;
    logic good;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                // First stage captures the raw line
                always_ff @(posedge clk_3125_rx or negedge rst_n) begin
                    if (!rst_n) begin
                        sync_reg[gi] <= 1'b1;
                    end else begin
                        sync_reg[gi] <= rx;
                    end
                end
            end else begin : g_next
                // Later stages resolve metastability from the previous stage
                always_ff @(posedge clk_3125_rx or negedge rst_n) begin
                    if (!rst_n) begin
                        sync_reg[gi] <= 1'b1;
                    end else begin
                        sync_reg[gi] <= sync_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign rx_s = sync_reg[SYNC_STAGES-1];

    // The received parity bit must match the parity the transmitter computes
    // from the data; the stop bit must sample high.
    assign p_ok = (par_bit_reg == ((^shift_reg) ^ parity_type));
    assign s_ok = rx_s;
    assign good = p_ok & s_ok;

    // Receive FSM: bit timing, deserialisation, checks and output pulses
    always_ff @(posedge clk_3125_rx or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            clk_cnt_reg     <= '0;
            bit_cnt_reg     <= '0;
            shift_reg       <= '0;
            par_bit_reg     <= 1'b0;
            rx_msg_reg      <= 8'h00;
            wr_en_reg       <= 1'b0;
            rx_complete_reg <= 1'b0;
            parity_err_reg  <= 1'b0;
            frame_err_reg   <= 1'b0;
            overrun_err_reg <= 1'b0;
        end else begin
            // Pulse outputs default low so each is high for one cycle only
            wr_en_reg       <= 1'b0;
            rx_complete_reg <= 1'b0;
            parity_err_reg  <= 1'b0;
            frame_err_reg   <= 1'b0;
            overrun_err_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    clk_cnt_reg <= '0;
                    if (!rx_s) begin
                        state_reg <= START;
                    end
                end

                START: begin
                    // Confirm the start bit near its middle; a short low
                    // glitch has already returned high by then.
                    if (clk_cnt_reg == CNT_SAMPLE) begin
                        clk_cnt_reg <= '0;
                        if (rx_s) begin
                            state_reg <= IDLE;
                        end else begin
                            bit_cnt_reg <= 3'd7;
                            state_reg   <= DATA;
                        end
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + CNT_ONE;
                    end
                end

                DATA: begin
                    // One full bit period after the start-bit midpoint lands
                    // on the middle of each data bit.
                    if (clk_cnt_reg == CNT_LAST) begin
                        clk_cnt_reg            <= '0;
                        shift_reg[bit_cnt_reg] <= rx_s;
                        if (bit_cnt_reg == 3'd0) begin
                            state_reg <= PARITY;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg - 3'd1;
                        end
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + CNT_ONE;
                    end
                end

                PARITY: begin
                    if (clk_cnt_reg == CNT_LAST) begin
                        clk_cnt_reg <= '0;
                        par_bit_reg <= rx_s;
                        state_reg   <= STOP;
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + CNT_ONE;
                    end
                end

                STOP: begin
                    // Mid-stop sample: report the frame and go idle at once so
                    // a start bit following right after the stop bit is caught.
                    if (clk_cnt_reg == CNT_LAST) begin
                        clk_cnt_reg     <= '0;
                        rx_msg_reg      <= shift_reg;
                        rx_complete_reg <= 1'b1;
                        parity_err_reg  <= ~p_ok;
                        frame_err_reg   <= ~s_ok;
                        wr_en_reg       <= good & ~ft_full;
                        overrun_err_reg <= good & ft_full;
                        state_reg       <= IDLE;
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + CNT_ONE;
                    end
                end

                default: begin
                    clk_cnt_reg <= '0;
                    state_reg   <= IDLE;
                end
            endcase
        end
    end

    assign rx_msg      = rx_msg_reg;
    assign wr_en       = wr_en_reg;
    assign rx_complete = rx_complete_reg;
    assign parity_err  = parity_err_reg;
    assign frame_err   = frame_err_reg;
    assign overrun_err = overrun_err_reg;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx. A serial transmitter model drives
// frames and pushes the expected frame report; a monitor pops and compares
// whenever the receiver emits any output pulse.

module tb_uart_rx;

    localparam int CPB = 14;

    logic       clk_3125_rx;
    logic       rst_n;
    logic       rx;
    logic       parity_type;
    logic       ft_full;
    logic [7:0] rx_msg;
    logic       wr_en;
    logic       rx_complete;
    logic       parity_err;
    logic       frame_err;
    logic       overrun_err;

    typedef struct packed {
        logic [7:0] msg;
        logic       wr;
        logic       perr;
        logic       ferr;
        logic       oerr;
    } exp_t;

    exp_t exp_q[$];
    int   wr_cyc_q[$];
    exp_t mon_e;

    int vectors_applied = 0;
    int miscompares     = 0;
    int cyc             = 0;
    int event_cnt       = 0;
    int fall_cyc        = 0;

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .SAMPLE_POINT(6)
    ) dut (
        .clk_3125_rx(clk_3125_rx),
        .rst_n      (rst_n),
        .rx         (rx),
        .parity_type(parity_type),
        .ft_full    (ft_full),
        .rx_msg     (rx_msg),
        .wr_en      (wr_en),
        .rx_complete(rx_complete),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun_err(overrun_err)
    );

    initial clk_3125_rx = 1'b0;
    always #5 clk_3125_rx = ~clk_3125_rx;

    always @(posedge clk_3125_rx) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors_applied++;
        if (obs !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Monitor: every output pulse must match the oldest expected frame report
    always @(negedge clk_3125_rx) begin
        if (rst_n && (rx_complete || wr_en || parity_err || frame_err || overrun_err)) begin
            event_cnt++;
            if (wr_en) wr_cyc_q.push_back(cyc);
            $display("frame @%0d: msg=%02h wr=%0b cmp=%0b perr=%0b ferr=%0b oerr=%0b",
                     cyc, rx_msg, wr_en, rx_complete, parity_err, frame_err, overrun_err);
            if (exp_q.size() == 0) begin
                check_val("unexpected_event", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("rx_complete", {31'd0, rx_complete}, 32'd1);
                check_val("rx_msg",      {24'd0, rx_msg},      {24'd0, mon_e.msg});
                check_val("wr_en",       {31'd0, wr_en},       {31'd0, mon_e.wr});
                check_val("parity_err",  {31'd0, parity_err},  {31'd0, mon_e.perr});
                check_val("frame_err",   {31'd0, frame_err},   {31'd0, mon_e.ferr});
                check_val("overrun_err", {31'd0, overrun_err}, {31'd0, mon_e.oerr});
            end
        end
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk_3125_rx);
        #1;
    endtask

    // Transmitter model: flip_par corrupts the parity bit, stop_bit sets the
    // stop level. The expected report is pushed before the frame goes out.
    task automatic send_frame(input logic [7:0] d, input logic flip_par, input logic stop_bit);
        logic par;
        logic good;
        exp_t e;
        par    = (^d) ^ parity_type ^ flip_par;
        good   = ~flip_par & stop_bit;
        e.msg  = d;
        e.perr = flip_par;
        e.ferr = ~stop_bit;
        e.wr   = good & ~ft_full;
        e.oerr = good & ft_full;
        exp_q.push_back(e);
        fall_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 7; i >= 0; i--) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(stop_bit);
        rx = 1'b1;
        @(posedge clk_3125_rx);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk_3125_rx);
        #1;
    endtask

    task automatic check_drained(input string tag);
        idle_cycles(20);
        check_val(tag, exp_q.size(), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ev_before;
        int lat;
        int gap;

        rst_n       = 1'b0;
        rx          = 1'b1;
        parity_type = 1'b0;
        ft_full     = 1'b0;
        repeat (3) @(negedge clk_3125_rx);
        check_val("rst_rx_msg",      {24'd0, rx_msg},   32'h00);
        check_val("rst_wr_en",       {31'd0, wr_en},    32'd0);
        check_val("rst_rx_complete", {31'd0, rx_complete}, 32'd0);
        check_val("rst_parity_err",  {31'd0, parity_err},  32'd0);
        check_val("rst_frame_err",   {31'd0, frame_err},   32'd0);
        check_val("rst_overrun_err", {31'd0, overrun_err}, 32'd0);
        @(posedge clk_3125_rx);
        #1;
        rst_n = 1'b1;
        idle_cycles(10);

        // 1: good A5, even parity, with latency check
        wr_cyc_q.delete();
        send_frame(8'hA5, 1'b0, 1'b1);
        check_drained("t1_drained");
        check_val("t1_wr_count", wr_cyc_q.size(), 32'd1);
        if (wr_cyc_q.size() >= 1) begin
            lat = wr_cyc_q[0] - fall_cyc;
            check_val("t1_latency_148_150", {31'd0, (lat >= 148 && lat <= 150)}, 32'd1);
        end

        // 2: A5 with wrong parity
        send_frame(8'hA5, 1'b1, 1'b1);
        check_drained("t2_drained");
        check_val("t2_rx_msg_held", {24'd0, rx_msg}, 32'hA5);

        // 3: 3-clock low glitch, then a quiet line
        ev_before = event_cnt;
        rx = 1'b0;
        repeat (3) @(posedge clk_3125_rx);
        #1;
        idle_cycles(300);
        check_val("t3_glitch_quiet", event_cnt - ev_before, 32'd0);

        // 4: overrun with FIFO full, then the same byte accepted
        ft_full = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b1);
        check_drained("t4a_drained");
        ft_full = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b1);
        check_drained("t4b_drained");

        // 5: stop bit forced low on 0F, then 55 decodes cleanly
        send_frame(8'h0F, 1'b0, 1'b0);
        idle_cycles(30);
        send_frame(8'h55, 1'b0, 1'b1);
        check_drained("t5_drained");

        // 6: reset in the middle of frame 81, then 7E with odd parity
        ev_before = event_cnt;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (2) @(negedge clk_3125_rx);
        check_val("t6_rst_rx_msg", {24'd0, rx_msg}, 32'h00);
        @(posedge clk_3125_rx);
        #1;
        rst_n = 1'b1;
        idle_cycles(200);
        check_val("t6_no_output_81", event_cnt - ev_before, 32'd0);
        parity_type = 1'b1;
        send_frame(8'h7E, 1'b0, 1'b1);
        check_drained("t6_drained");

        // 7: back-to-back 00 then FF with odd parity
        wr_cyc_q.delete();
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        check_drained("t7_drained");
        check_val("t7_wr_count", wr_cyc_q.size(), 32'd2);
        if (wr_cyc_q.size() >= 2) begin
            gap = wr_cyc_q[1] - wr_cyc_q[0];
            check_val("t7_gap_150_155", {31'd0, (gap >= 150 && gap <= 155)}, 32'd1);
        end
        check_val("t7_last_msg", {24'd0, rx_msg}, 32'hFF);

        check_val("sb_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
